// File: rtl/env_pkg.sv
// Shared definitions for the CartPole environment control register block:
// register byte offsets, STATUS bit positions, command encodings, state word width
// and the command sequencer state type.
package env_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned Q_W     = 32;           // one Q16.16 state word
  localparam int unsigned STATE_W = 4 * Q_W;      // {theta_dot, theta, x_dot, x}

  // Register byte offsets
  localparam int unsigned OFF_CTRL      = 'h00;
  localparam int unsigned OFF_ACTION    = 'h04;
  localparam int unsigned OFF_STATUS    = 'h08;
  localparam int unsigned OFF_STEP_CNT  = 'h0C;
  localparam int unsigned OFF_EP_CNT    = 'h10;
  localparam int unsigned OFF_X         = 'h14;
  localparam int unsigned OFF_X_DOT     = 'h18;
  localparam int unsigned OFF_THETA     = 'h1C;
  localparam int unsigned OFF_THETA_DOT = 'h20;
  localparam int unsigned OFF_VERSION   = 'h24;
  localparam int unsigned OFF_SCRATCH   = 'h28;

  // CTRL bit positions
  localparam int unsigned CTRL_RESET = 0;
  localparam int unsigned CTRL_STEP  = 1;
  localparam int unsigned CTRL_CLEAR = 31;

  // STATUS bit positions
  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_DONE    = 1;
  localparam int unsigned STAT_VALID   = 2;
  localparam int unsigned STAT_TIMEOUT = 3;
  localparam int unsigned STAT_DROPPED = 4;

  // Command encodings on o_env_cmd
  localparam logic CMD_STEP  = 1'b0;
  localparam logic CMD_RESET = 1'b1;

  typedef enum logic {
    CS_IDLE = 1'b0,
    CS_REQ  = 1'b1
  } cmd_state_e;

endpackage

// File: rtl/axil_slave_if.sv
// AXI4-Lite slave handshake front end.
// Write side: accepts one address+data pair at a time (awready/wready pulse together),
// exposes a one-cycle write strobe with word index/data/strobes, then holds bvalid
// until bready. Read side: pulses arready, samples the register mux at the handshake
// edge and holds rvalid/rdata until rready.
// Ports: i_clk/i_rst, AXI-Lite slave channels, o_wr_*_c register write interface,
// o_rd_idx_c/i_rd_data register read mux interface.
module axil_slave_if #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_awvalid,
  output logic              o_awready,
  input  logic [ADDR_W-1:0] i_awaddr,
  input  logic              i_wvalid,
  output logic              o_wready,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_wstrb,
  output logic              o_bvalid,
  input  logic              i_bready,
  output logic [1:0]        o_bresp,
  input  logic              i_arvalid,
  output logic              o_arready,
  input  logic [ADDR_W-1:0] i_araddr,
  output logic              o_rvalid,
  input  logic              i_rready,
  output logic [31:0]       o_rdata,
  output logic [1:0]        o_rresp,
  output logic              o_wr_en_c,
  output logic [ADDR_W-3:0] o_wr_idx_c,
  output logic [31:0]       o_wr_data_c,
  output logic [3:0]        o_wr_strb_c,
  output logic [ADDR_W-3:0] o_rd_idx_c,
  input  logic [31:0]       i_rd_data
);

  logic        awready_q;
  logic        bvalid_q;
  logic        arready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        wr_hs;
  logic        rd_hs;

  // Byte-lane bits of the addresses carry no information for word registers
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{i_awaddr[1:0], i_araddr[1:0]};

  assign wr_hs = awready_q & i_awvalid & i_wvalid;
  assign rd_hs = arready_q & i_arvalid;

  assign o_wr_en_c   = wr_hs;
  assign o_wr_idx_c  = i_awaddr[ADDR_W-1:2];
  assign o_wr_data_c = i_wdata;
  assign o_wr_strb_c = i_wstrb;
  assign o_rd_idx_c  = i_araddr[ADDR_W-1:2];

  assign o_awready = awready_q;
  assign o_wready  = awready_q;
  assign o_bvalid  = bvalid_q;
  assign o_bresp   = 2'b00;
  assign o_arready = arready_q;
  assign o_rvalid  = rvalid_q;
  assign o_rdata   = rdata_q;
  assign o_rresp   = 2'b00;

  // Ready is a single-cycle pulse; the !ready term stops a second accept of the same beat
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      awready_q <= i_awvalid & i_wvalid & ~bvalid_q & ~awready_q;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
      end else if (i_bready) begin
        bvalid_q <= 1'b0;
      end

      arready_q <= i_arvalid & ~rvalid_q & ~arready_q;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= i_rd_data;
      end else if (i_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/env_ctrl_regs.sv
// CartPole environment control register block.
// Host writes ACTION/CTRL over AXI4-Lite; CTRL commands are sequenced to the
// environment core via a level req / pulse ack handshake with a timeout, and the
// returned state, done flag and step/episode counters are exposed for readback.
// Ports: i_clk/i_rst, AXI-Lite slave (aw/w/b/ar/r), o_env_req/o_env_cmd/o_env_action
// to the core, i_env_ack/i_env_state/i_env_done from the core.
module env_ctrl_regs
  import env_pkg::*;
#(
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] VERSION        = 32'h4350_0001
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_awvalid,
  output logic               o_awready,
  input  logic [ADDR_W-1:0]  i_awaddr,
  input  logic               i_wvalid,
  output logic               o_wready,
  input  logic [31:0]        i_wdata,
  input  logic [3:0]         i_wstrb,
  output logic               o_bvalid,
  input  logic               i_bready,
  output logic [1:0]         o_bresp,
  input  logic               i_arvalid,
  output logic               o_arready,
  input  logic [ADDR_W-1:0]  i_araddr,
  output logic               o_rvalid,
  input  logic               i_rready,
  output logic [31:0]        o_rdata,
  output logic [1:0]         o_rresp,
  output logic               o_env_req,
  output logic               o_env_cmd,
  output logic               o_env_action,
  input  logic               i_env_ack,
  input  logic [STATE_W-1:0] i_env_state,
  input  logic               i_env_done
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic             wr_en_c;
  logic [IDX_W-1:0] wr_idx_c;
  logic [31:0]      wr_data_c;
  logic [3:0]       wr_strb_c;
  logic [IDX_W-1:0] rd_idx_c;
  logic [31:0]      rd_data_c;
  logic [31:0]      status_c;

  cmd_state_e          state_q;
  logic [TMO_W-1:0]    tmo_cnt_q;
  logic                env_req_q;
  logic                env_cmd_q;
  logic                env_action_q;
  logic                action_q;
  logic [31:0]         scratch_q;
  logic [31:0]         step_cnt_q;
  logic [31:0]         ep_cnt_q;
  logic [3:0][Q_W-1:0] env_state_q;
  logic                done_q;
  logic                valid_q;
  logic                timeout_q;
  logic                dropped_q;

  logic ctrl_wr_c;
  logic cmd_reset_c;
  logic cmd_step_c;
  logic cmd_clear_c;

  axil_slave_if #(.ADDR_W(ADDR_W)) u_axil (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_awvalid   (i_awvalid),
    .o_awready   (o_awready),
    .i_awaddr    (i_awaddr),
    .i_wvalid    (i_wvalid),
    .o_wready    (o_wready),
    .i_wdata     (i_wdata),
    .i_wstrb     (i_wstrb),
    .o_bvalid    (o_bvalid),
    .i_bready    (i_bready),
    .o_bresp     (o_bresp),
    .i_arvalid   (i_arvalid),
    .o_arready   (o_arready),
    .i_araddr    (i_araddr),
    .o_rvalid    (o_rvalid),
    .i_rready    (i_rready),
    .o_rdata     (o_rdata),
    .o_rresp     (o_rresp),
    .o_wr_en_c   (wr_en_c),
    .o_wr_idx_c  (wr_idx_c),
    .o_wr_data_c (wr_data_c),
    .o_wr_strb_c (wr_strb_c),
    .o_rd_idx_c  (rd_idx_c),
    .i_rd_data   (rd_data_c)
  );

  assign o_env_req    = env_req_q;
  assign o_env_cmd    = env_cmd_q;
  assign o_env_action = env_action_q;

  // CTRL pulses; each bit needs its byte lane strobed
  assign ctrl_wr_c   = wr_en_c && (wr_idx_c == IDX_W'(OFF_CTRL / 4));
  assign cmd_reset_c = ctrl_wr_c & wr_data_c[CTRL_RESET] & wr_strb_c[0];
  assign cmd_step_c  = ctrl_wr_c & wr_data_c[CTRL_STEP]  & wr_strb_c[0];
  assign cmd_clear_c = ctrl_wr_c & wr_data_c[CTRL_CLEAR] & wr_strb_c[3];

  always_comb begin
    status_c               = '0;
    status_c[STAT_BUSY]    = (state_q == CS_REQ);
    status_c[STAT_DONE]    = done_q;
    status_c[STAT_VALID]   = valid_q;
    status_c[STAT_TIMEOUT] = timeout_q;
    status_c[STAT_DROPPED] = dropped_q;
  end

  // Read mux; sampled by the slave at the read handshake edge (pre-update values)
  always_comb begin
    rd_data_c = '0;
    case (rd_idx_c)
      IDX_W'(OFF_ACTION / 4):    rd_data_c = {31'b0, action_q};
      IDX_W'(OFF_STATUS / 4):    rd_data_c = status_c;
      IDX_W'(OFF_STEP_CNT / 4):  rd_data_c = step_cnt_q;
      IDX_W'(OFF_EP_CNT / 4):    rd_data_c = ep_cnt_q;
      IDX_W'(OFF_X / 4):         rd_data_c = env_state_q[0];
      IDX_W'(OFF_X_DOT / 4):     rd_data_c = env_state_q[1];
      IDX_W'(OFF_THETA / 4):     rd_data_c = env_state_q[2];
      IDX_W'(OFF_THETA_DOT / 4): rd_data_c = env_state_q[3];
      IDX_W'(OFF_VERSION / 4):   rd_data_c = VERSION;
      IDX_W'(OFF_SCRATCH / 4):   rd_data_c = scratch_q;
      default:                   rd_data_c = '0;
    endcase
  end

  // Register file and command sequencer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= CS_IDLE;
      tmo_cnt_q    <= '0;
      env_req_q    <= 1'b0;
      env_cmd_q    <= CMD_STEP;
      env_action_q <= 1'b0;
      action_q     <= 1'b0;
      scratch_q    <= '0;
      step_cnt_q   <= '0;
      ep_cnt_q     <= '0;
      env_state_q  <= '0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      if (wr_en_c && (wr_idx_c == IDX_W'(OFF_ACTION / 4)) && wr_strb_c[0]) begin
        action_q <= wr_data_c[0];
      end
      if (wr_en_c && (wr_idx_c == IDX_W'(OFF_SCRATCH / 4))) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_strb_c[b]) scratch_q[8*b +: 8] <= wr_data_c[8*b +: 8];
        end
      end

      // Clear comes first so a drop in the same write still lands
      if (cmd_clear_c) begin
        timeout_q <= 1'b0;
        dropped_q <= 1'b0;
      end

      case (state_q)
        CS_IDLE: begin
          if (cmd_reset_c || cmd_step_c) begin
            state_q      <= CS_REQ;
            env_req_q    <= 1'b1;
            env_cmd_q    <= cmd_reset_c ? CMD_RESET : CMD_STEP;
            env_action_q <= action_q;
            tmo_cnt_q    <= '0;
            // Reset wins over a simultaneous step
            if (cmd_reset_c && cmd_step_c) dropped_q <= 1'b1;
          end
        end
        CS_REQ: begin
          if (cmd_reset_c || cmd_step_c) dropped_q <= 1'b1;
          if (i_env_ack) begin
            state_q     <= CS_IDLE;
            env_req_q   <= 1'b0;
            env_state_q <= i_env_state;
            done_q      <= i_env_done;
            valid_q     <= 1'b1;
            if (env_cmd_q == CMD_RESET) begin
              step_cnt_q <= '0;
              if (ep_cnt_q != '1) ep_cnt_q <= ep_cnt_q + 32'd1;
            end else begin
              step_cnt_q <= step_cnt_q + 32'd1;
            end
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_q   <= CS_IDLE;
            env_req_q <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        default: begin
          state_q   <= CS_IDLE;
          env_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_env_ctrl_regs.sv
// Testbench for env_ctrl_regs: directed test-plan steps followed by randomized
// register/command traffic, checked against a register-level reference model.
module tb_env_ctrl_regs;

  localparam int unsigned TMO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic [5:0]   awaddr, araddr;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic         arvalid, arready, rvalid, rready;
  logic         env_req, env_cmd, env_action, env_ack, env_done;
  logic [127:0] env_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model of the architectural registers
  logic        m_action;
  logic [31:0] m_scratch, m_step, m_ep;
  logic [31:0] m_st [4];
  logic        m_done, m_valid, m_timeout, m_dropped;

  env_ctrl_regs #(.ADDR_W(6), .TIMEOUT_CYCLES(TMO), .VERSION(32'h4350_0001)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_awvalid(awvalid), .o_awready(awready), .i_awaddr(awaddr),
    .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata), .i_wstrb(wstrb),
    .o_bvalid(bvalid), .i_bready(bready), .o_bresp(bresp),
    .i_arvalid(arvalid), .o_arready(arready), .i_araddr(araddr),
    .o_rvalid(rvalid), .i_rready(rready), .o_rdata(rdata), .o_rresp(rresp),
    .o_env_req(env_req), .o_env_cmd(env_cmd), .o_env_action(env_action),
    .i_env_ack(env_ack), .i_env_state(env_state), .i_env_done(env_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status(input logic busy);
    return {27'b0, m_dropped, m_timeout, m_valid, m_done, busy};
  endfunction

  function automatic logic [31:0] exp_reg(input int idx);
    case (idx)
      1:       return {31'b0, m_action};
      2:       return m_status(1'b0);
      3:       return m_step;
      4:       return m_ep;
      5:       return m_st[0];
      6:       return m_st[1];
      7:       return m_st[2];
      8:       return m_st[3];
      9:       return 32'h4350_0001;
      10:      return m_scratch;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_action = 1'b0; m_scratch = '0; m_step = '0; m_ep = '0;
    for (int i = 0; i < 4; i++) m_st[i] = '0;
    m_done = 1'b0; m_valid = 1'b0; m_timeout = 1'b0; m_dropped = 1'b0;
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    logic ok;
    ok = 1'b0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("write_handshake", {31'b0, ok}, 32'd1);
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
    logic ok1, ok2;
    ok1 = 1'b0; ok2 = 1'b0; d = 'x;
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) begin ok1 = 1'b1; break; end
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rvalid) begin ok2 = 1'b1; d = rdata; break; end
    end
    @(posedge clk); #1;
    check("read_handshake", {31'b0, ok1 & ok2}, 32'd1);
  endtask

  task automatic reg_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    axi_write(a, d, s);
    if (a == 6'h04 && s[0]) m_action = d[0];
    if (a == 6'h28)
      for (int b = 0; b < 4; b++) if (s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic check_all();
    logic [31:0] r;
    for (int i = 0; i < 16; i++) begin
      axi_read(6'(i * 4), r);
      check($sformatf("reg_%02h", i * 4), r, exp_reg(i));
    end
  endtask

  // One CTRL write plus the resulting command lifetime.
  // ack_delay == 0 means the core never answers.
  task automatic do_cmd(input logic [31:0] d, input logic [3:0] s, input logic second,
                        input logic [31:0] second_d, input int ack_delay,
                        input logic [127:0] st, input logic dn);
    logic rs, sp, fell;
    logic [31:0] r;
    int c0;
    if (d[31] && s[3]) begin m_timeout = 1'b0; m_dropped = 1'b0; end
    rs = d[0] & s[0];
    sp = d[1] & s[0];
    if (rs && sp) m_dropped = 1'b1;
    axi_write(6'h00, d, s);
    c0 = cyc;
    if (!(rs || sp)) begin
      check("no_req", {31'b0, env_req}, 32'd0);
      return;
    end
    check("req_rise", {31'b0, env_req}, 32'd1);
    check("req_cmd", {31'b0, env_cmd}, {31'b0, rs});
    check("req_action", {31'b0, env_action}, {31'b0, m_action});
    axi_read(6'h08, r);
    check("status_busy", r, m_status(1'b1));
    if (second) begin
      if (second_d[31]) begin m_timeout = 1'b0; m_dropped = 1'b0; end
      if (second_d[1:0] != 2'b00) m_dropped = 1'b1;
      axi_write(6'h00, second_d, 4'hF);
      check("req_held", {31'b0, env_req}, 32'd1);
      check("cmd_held", {31'b0, env_cmd}, {31'b0, rs});
    end
    if (ack_delay == 0) begin
      fell = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (!env_req) begin fell = 1'b1; break; end
      end
      check("timeout_fell", {31'b0, fell}, 32'd1);
      check("timeout_len", 32'(cyc - c0), TMO);
      m_timeout = 1'b1;
      @(posedge clk); #1;
    end else begin
      repeat (ack_delay - 1) @(posedge clk);
      #1;
      env_ack = 1'b1; env_state = st; env_done = dn;
      @(posedge clk); #1;
      env_ack = 1'b0; env_state = '0; env_done = 1'b0;
      check("req_fall", {31'b0, env_req}, 32'd0);
      if (rs) begin
        m_step = '0;
        if (m_ep != 32'hFFFF_FFFF) m_ep = m_ep + 32'd1;
      end else begin
        m_step = m_step + 32'd1;
      end
      for (int i = 0; i < 4; i++) m_st[i] = st[32*i +: 32];
      m_done = dn; m_valid = 1'b1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] r, d, d2;
    logic [3:0]  s;
    logic        ok;
    int          op, kind;

    awvalid = 0; wvalid = 0; arvalid = 0; awaddr = '0; araddr = '0;
    wdata = '0; wstrb = '0; bready = 1'b1; rready = 1'b1;
    env_ack = 1'b0; env_state = '0; env_done = 1'b0;
    model_reset();
    apply_reset();

    // Reset state
    check("rst_awready", {31'b0, awready}, 0);
    check("rst_wready", {31'b0, wready}, 0);
    check("rst_bvalid", {31'b0, bvalid}, 0);
    check("rst_arready", {31'b0, arready}, 0);
    check("rst_rvalid", {31'b0, rvalid}, 0);
    check("rst_req", {31'b0, env_req}, 0);
    check("rst_cmd", {31'b0, env_cmd}, 0);
    check("rst_action", {31'b0, env_action}, 0);
    axi_read(6'h24, r); check("version", r, 32'h4350_0001);
    axi_read(6'h3C, r); check("unmapped_3c", r, 32'h0);
    axi_read(6'h08, r); check("status_reset", r, 32'h0);
    check_all();

    // Step with ACTION=1, ack after 5 cycles with {4,3,2,1}
    reg_write(6'h04, 32'h1, 4'hF);
    do_cmd(32'h2, 4'hF, 1'b0, 32'h0, 5, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
    axi_read(6'h14, r); check("state_x", r, 32'd1);
    axi_read(6'h20, r); check("theta_dot", r, 32'd4);
    axi_read(6'h0C, r); check("step_cnt_1", r, 32'd1);
    axi_read(6'h08, r); check("status_after_step", r, 32'h4);

    // Simultaneous reset+step: reset wins, step dropped
    do_cmd(32'h3, 4'hF, 1'b0, 32'h0, 3, {4{32'h0001_0000}}, 1'b0);
    axi_read(6'h10, r); check("ep_cnt_1", r, 32'd1);
    axi_read(6'h0C, r); check("step_cnt_0", r, 32'd0);
    axi_read(6'h08, r); check("status_dropped", r, 32'h14);
    do_cmd(32'h8000_0000, 4'hF, 1'b0, 32'h0, 1, '0, 1'b0);
    axi_read(6'h08, r); check("status_cleared", r, 32'h4);

    // Step while busy: second command dropped
    do_cmd(32'h2, 4'hF, 1'b1, 32'h2, 3, {32'd8, 32'd7, 32'd6, 32'd5}, 1'b1);
    axi_read(6'h0C, r); check("step_cnt_busy", r, 32'd1);
    axi_read(6'h08, r); check("status_busy_drop", r, 32'h16);
    check_all();

    // Back-pressure on both response channels
    bready = 1'b0; rready = 1'b0;
    reg_write(6'h28, 32'hA5A5_1234, 4'hF);
    araddr = 6'h28; arvalid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1 arvalid = 1'b0;
    check("stall_ar_hs", {31'b0, ok}, 32'd1);
    awaddr = 6'h28; wdata = 32'h5A5A_0000; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_bvalid", {31'b0, bvalid}, 32'd1);
      check("stall_rvalid", {31'b0, rvalid}, 32'd1);
      check("stall_rdata", rdata, 32'hA5A5_1234);
      check("stall_no_aw", {31'b0, awready}, 32'd0);
    end
    check("bresp", {30'b0, bresp}, 32'd0);
    check("rresp", {30'b0, rresp}, 32'd0);
    bready = 1'b1; rready = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    check("stall_release_aw", {31'b0, ok}, 32'd1);
    m_scratch = 32'h5A5A_0000;
    axi_read(6'h28, r); check("scratch_after_stall", r, 32'h5A5A_0000);

    // Reset during an outstanding request
    axi_write(6'h00, 32'h2, 4'hF);
    check("req_before_rst", {31'b0, env_req}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_req", {31'b0, env_req}, 0);
    check("mid_rst_cmd", {31'b0, env_cmd}, 0);
    check("mid_rst_action", {31'b0, env_action}, 0);
    check("mid_rst_bvalid", {31'b0, bvalid}, 0);
    check("mid_rst_rvalid", {31'b0, rvalid}, 0);
    check("mid_rst_awready", {31'b0, awready}, 0);
    check("mid_rst_arready", {31'b0, arready}, 0);
    rst = 1'b0;
    model_reset();
    check_all();

    // Timeout from a fresh state
    do_cmd(32'h2, 4'hF, 1'b0, 32'h0, 0, '0, 1'b0);
    axi_read(6'h08, r); check("status_timeout", r, 32'h8);
    axi_read(6'h0C, r); check("step_cnt_timeout", r, 32'd0);

    // Randomized traffic against the model
    for (int it = 0; it < 50; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
          reg_write(6'h04, $urandom, s);
        end
        1: reg_write(6'h28, $urandom, 4'($urandom));
        2, 3: begin
          kind = $urandom_range(0, 3);
          d = $urandom & 32'h7FFF_FFFC;
          d[1:0] = (kind == 0) ? 2'b10 : (kind == 1) ? 2'b01 : (kind == 2) ? 2'b11 : 2'b00;
          d[31] = ($urandom_range(0, 3) == 0);
          s = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
          d2 = {($urandom_range(0, 1) == 1), 29'b0, 2'($urandom_range(1, 3))};
          do_cmd(d, s, ($urandom_range(0, 3) == 0), d2, $urandom_range(0, 5),
                 {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
        end
        default: begin
          // Ack while idle must change nothing
          env_ack = 1'b1; env_state = {$urandom, $urandom, $urandom, $urandom}; env_done = 1'b1;
          @(posedge clk); #1;
          env_ack = 1'b0; env_state = '0; env_done = 1'b0;
          check("idle_ack_no_req", {31'b0, env_req}, 32'd0);
        end
      endcase
      check_all();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
